// File: rtl/sdrc_burst_sequencer.sv
// Turns one 256-bit line request into an ACTIVE + 8-word WRITE/READ burst on the SDRAM controller
// command port, then returns a one-cycle completion with the read line.
module sdrc_burst_sequencer #(
  parameter int T_RCD  = 4,
  parameter int T_RP   = 3,
  parameter int RD_LAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [17:0]  req_line_addr,
  input  logic [255:0] req_wdata,
  output logic         rsp_valid,
  output logic         rsp_write,
  output logic [255:0] rsp_rdata,
  input  logic         sdrc_init_done,
  output logic         sdrc_cmd_en,
  output logic [2:0]   sdrc_cmd,
  output logic         sdrc_precharge_ctrl,
  output logic         sdrc_power_down,
  output logic         sdrc_selfrefresh,
  output logic [20:0]  sdrc_addr,
  output logic [3:0]   sdrc_dqm,
  output logic [31:0]  sdrc_wdata,
  output logic [7:0]   sdrc_data_len,
  input  logic [31:0]  sdrc_rdata
);

  localparam int WAIT_MAX = (T_RCD > T_RP) ? ((T_RCD > RD_LAT + 7) ? T_RCD : RD_LAT + 7)
                                           : ((T_RP > RD_LAT + 7) ? T_RP : RD_LAT + 7);
  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  localparam logic [2:0] CMD_ACTIVE   = 3'b011;
  localparam logic [2:0] CMD_WRITE    = 3'b100;
  localparam logic [2:0] CMD_READ     = 3'b101;
  localparam logic [7:0] BURST_LEN_M1 = 8'd7;

  typedef enum logic [2:0] {IDLE, ACT, RCD, WR, RD_CMD, RD_DATA, RP, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   wait_reg, wait_next;
  logic [2:0]         wr_idx_reg, wr_idx_next;
  logic [2:0]         rd_idx_reg, rd_idx_next;
  logic [2:0]         cmd_reg, cmd_next;
  logic [20:0]        addr_reg, addr_next;
  logic [7:0]         len_reg, len_next;
  logic               req_write_reg;
  logic [17:0]        line_reg;
  logic [255:0]       wdata_reg;
  logic [31:0]        rd_buf_reg [8];
  logic [255:0]       rsp_rdata_reg;
  logic [31:0]        wr_word [8];
  logic [255:0]       rd_line;
  logic               accept, capture, load_rsp;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_words
      assign wr_word[gi]            = wdata_reg[32*gi +: 32];
      assign rd_line[32*gi +: 32]   = rd_buf_reg[gi];
    end
  endgenerate

  assign req_ready           = (state_reg == IDLE) && sdrc_init_done && !rst;
  assign accept              = req_valid && req_ready;
  assign rsp_valid           = (state_reg == DONE);
  assign rsp_write           = (state_reg == DONE) && req_write_reg;
  assign rsp_rdata           = rsp_rdata_reg;
  assign sdrc_precharge_ctrl = 1'b1;
  assign sdrc_power_down     = 1'b0;
  assign sdrc_selfrefresh    = 1'b0;
  assign sdrc_dqm            = 4'b0000;
  // Command fields are registered so they hold their last value between strobes.
  assign sdrc_cmd            = cmd_next;
  assign sdrc_addr           = addr_next;
  assign sdrc_data_len       = len_next;

  always_comb begin
    state_next  = state_reg;
    wait_next   = wait_reg;
    wr_idx_next = wr_idx_reg;
    rd_idx_next = rd_idx_reg;
    cmd_next    = cmd_reg;
    addr_next   = addr_reg;
    len_next    = len_reg;
    sdrc_cmd_en = 1'b0;
    sdrc_wdata  = '0;
    capture     = 1'b0;
    load_rsp    = 1'b0;
    unique case (state_reg)
      IDLE: if (accept) state_next = ACT;
      ACT: begin
        sdrc_cmd_en = 1'b1;
        cmd_next    = CMD_ACTIVE;
        addr_next   = {line_reg, 3'b000};
        wait_next   = '0;
        state_next  = RCD;
      end
      RCD: begin
        if (wait_reg == CNT_W'(T_RCD - 1)) begin
          wait_next   = '0;
          wr_idx_next = '0;
          state_next  = req_write_reg ? WR : RD_CMD;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      WR: begin
        sdrc_wdata = wr_word[wr_idx_reg];
        if (wr_idx_reg == 3'd0) begin
          sdrc_cmd_en = 1'b1;
          cmd_next    = CMD_WRITE;
          addr_next   = {line_reg, 3'b000};
          len_next    = BURST_LEN_M1;
        end
        wr_idx_next = wr_idx_reg + 3'd1;
        if (wr_idx_reg == 3'd7) begin
          wait_next  = '0;
          state_next = RP;
        end
      end
      RD_CMD: begin
        sdrc_cmd_en = 1'b1;
        cmd_next    = CMD_READ;
        addr_next   = {line_reg, 3'b000};
        len_next    = BURST_LEN_M1;
        wait_next   = '0;
        rd_idx_next = '0;
        state_next  = RD_DATA;
      end
      RD_DATA: begin
        // Counter parks at RD_LAT-1 once the first word is due; one word per cycle after that.
        if (wait_reg == CNT_W'(RD_LAT - 1)) begin
          capture     = 1'b1;
          rd_idx_next = rd_idx_reg + 3'd1;
          if (rd_idx_reg == 3'd7) begin
            wait_next  = '0;
            state_next = RP;
          end
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      RP: begin
        if (wait_reg == CNT_W'(T_RP - 1)) begin
          wait_next  = '0;
          load_rsp   = !req_write_reg;
          state_next = DONE;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      wait_reg      <= '0;
      wr_idx_reg    <= '0;
      rd_idx_reg    <= '0;
      cmd_reg       <= '0;
      addr_reg      <= '0;
      len_reg       <= '0;
      req_write_reg <= 1'b0;
      line_reg      <= '0;
      wdata_reg     <= '0;
      rsp_rdata_reg <= '0;
      for (int i = 0; i < 8; i++) rd_buf_reg[i] <= '0;
    end else begin
      state_reg  <= state_next;
      wait_reg   <= wait_next;
      wr_idx_reg <= wr_idx_next;
      rd_idx_reg <= rd_idx_next;
      cmd_reg    <= cmd_next;
      addr_reg   <= addr_next;
      len_reg    <= len_next;
      if (accept) begin
        req_write_reg <= req_write;
        line_reg      <= req_line_addr;
        wdata_reg     <= req_wdata;
      end
      if (capture) rd_buf_reg[rd_idx_reg] <= sdrc_rdata;
      // Response line only changes when a read completes, so it survives intervening writes.
      if (load_rsp) rsp_rdata_reg <= rd_line;
    end
  end

endmodule

// File: tb/tb_sdrc_burst_sequencer.sv
// Bench for sdrc_burst_sequencer: default and swept-parameter instances, a behavioural SDRAM
// controller responder, and a timing/data reference derived from the request rules.
`timescale 1ns/1ps
module tb_sdrc_burst_sequencer;
  localparam int N = 8192;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sdrc_init_done = 1'b0;
  logic         req_write = 1'b0;
  logic [17:0]  req_line_addr = '0;
  logic [255:0] req_wdata = '0;
  logic [31:0]  sdrc_rdata_drv = '0;

  logic         req_valid [2];
  logic         req_ready [2];
  logic         rsp_valid [2];
  logic         rsp_write [2];
  logic [255:0] rsp_rdata [2];
  logic         sdrc_cmd_en [2];
  logic [2:0]   sdrc_cmd [2];
  logic         sdrc_pc [2];
  logic         sdrc_pd [2];
  logic         sdrc_sr [2];
  logic [20:0]  sdrc_addr [2];
  logic [3:0]   sdrc_dqm [2];
  logic [31:0]  sdrc_wdata [2];
  logic [7:0]   sdrc_len [2];

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int cur = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sdrc_burst_sequencer u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write), .req_line_addr(req_line_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_write(rsp_write[0]), .rsp_rdata(rsp_rdata[0]),
    .sdrc_init_done(sdrc_init_done), .sdrc_cmd_en(sdrc_cmd_en[0]), .sdrc_cmd(sdrc_cmd[0]),
    .sdrc_precharge_ctrl(sdrc_pc[0]), .sdrc_power_down(sdrc_pd[0]), .sdrc_selfrefresh(sdrc_sr[0]),
    .sdrc_addr(sdrc_addr[0]), .sdrc_dqm(sdrc_dqm[0]), .sdrc_wdata(sdrc_wdata[0]),
    .sdrc_data_len(sdrc_len[0]), .sdrc_rdata(sdrc_rdata_drv)
  );

  sdrc_burst_sequencer #(.T_RCD(2), .T_RP(5), .RD_LAT(6)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write), .req_line_addr(req_line_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_write(rsp_write[1]), .rsp_rdata(rsp_rdata[1]),
    .sdrc_init_done(sdrc_init_done), .sdrc_cmd_en(sdrc_cmd_en[1]), .sdrc_cmd(sdrc_cmd[1]),
    .sdrc_precharge_ctrl(sdrc_pc[1]), .sdrc_power_down(sdrc_pd[1]), .sdrc_selfrefresh(sdrc_sr[1]),
    .sdrc_addr(sdrc_addr[1]), .sdrc_dqm(sdrc_dqm[1]), .sdrc_wdata(sdrc_wdata[1]),
    .sdrc_data_len(sdrc_len[1]), .sdrc_rdata(sdrc_rdata_drv)
  );

  function automatic int rcd_of(input int d); return (d != 0) ? 2 : 4; endfunction
  function automatic int rp_of(input int d);  return (d != 0) ? 5 : 3; endfunction
  function automatic int lat_of(input int d); return (d != 0) ? 6 : 4; endfunction
  function automatic int txn_lat(input int d, input logic wr);
    return wr ? (1 + 1 + rcd_of(d) + 8 + rp_of(d))
              : (1 + 1 + rcd_of(d) + 1 + lat_of(d) + 7 + rp_of(d));
  endfunction

  function automatic logic [255:0] default_line(input logic [17:0] l);
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[32*w +: 32] = {l, 6'(w), 8'ha5};
    return r;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[32*w +: 32] = $urandom;
    return r;
  endfunction

  // Controller-side memory (what the DUT actually wrote) and the request scoreboard.
  logic [255:0] mem [logic [17:0]];
  logic [255:0] sb  [logic [17:0]];
  logic [255:0] exp_hold [2];

  function automatic logic [255:0] mem_line(input logic [17:0] l);
    return mem.exists(l) ? mem[l] : default_line(l);
  endfunction
  function automatic logic [255:0] sb_line(input logic [17:0] l);
    return sb.exists(l) ? sb[l] : default_line(l);
  endfunction

  // Per-cycle trace of the DUT under test, plus the SDRAM responder.
  logic         tr_en [N];
  logic [2:0]   tr_cmd [N];
  logic [20:0]  tr_addr [N];
  logic [7:0]   tr_len [N];
  logic [31:0]  tr_wd [N];
  logic         tr_rv [N];
  logic         tr_rw [N];
  logic [255:0] last_rsp_rdata = '0;
  logic         rd_active = 1'b0, wr_active = 1'b0;
  logic [17:0]  rd_line_m = '0, wr_line_m = '0;
  logic [255:0] tmp_line;
  int           rd_start = 0, wr_start = 0, idx, mt;

  always @(negedge clk) begin
    mt = cyc % N;
    tr_en[mt]   = sdrc_cmd_en[cur];
    tr_cmd[mt]  = sdrc_cmd[cur];
    tr_addr[mt] = sdrc_addr[cur];
    tr_len[mt]  = sdrc_len[cur];
    tr_wd[mt]   = sdrc_wdata[cur];
    tr_rv[mt]   = rsp_valid[cur];
    tr_rw[mt]   = rsp_write[cur];
    if (rsp_valid[cur]) last_rsp_rdata = rsp_rdata[cur];
    if (rst) begin
      rd_active = 1'b0;
      wr_active = 1'b0;
    end else if (sdrc_cmd_en[cur]) begin
      if (sdrc_cmd[cur] == 3'b101) begin
        rd_active = 1'b1; rd_start = cyc; rd_line_m = sdrc_addr[cur][20:3];
      end
      if (sdrc_cmd[cur] == 3'b100) begin
        wr_active = 1'b1; wr_start = cyc; wr_line_m = sdrc_addr[cur][20:3];
      end
    end
    if (wr_active && (cyc - wr_start) < 8) begin
      tmp_line = mem_line(wr_line_m);
      tmp_line[32*(cyc - wr_start) +: 32] = sdrc_wdata[cur];
      mem[wr_line_m] = tmp_line;
    end
    idx = cyc - rd_start - lat_of(cur);
    if (rd_active && idx >= 0 && idx < 8) begin
      tmp_line = mem_line(rd_line_m);
      sdrc_rdata_drv = tmp_line[32*idx +: 32];
    end else begin
      sdrc_rdata_drv = $urandom;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_accept(input int d, output int acc, output logic ok);
    ok = 1'b0;
    acc = 0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (req_ready[d] && req_valid[d]) begin
        acc = cyc; ok = 1'b1; break;
      end
      @(negedge clk);
    end
    chk("accept_seen", ok, 1'b1);
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic check_txn(input int d, input int acc, input logic wr, input logic [17:0] line,
                           input logic [255:0] wd);
    int l, c2, bad_en, bad_wd, bad_rv, m;
    logic [31:0] exp_wd;
    logic [2:0] cmd2;
    l = txn_lat(d, wr);
    c2 = acc + 2 + rcd_of(d);
    cmd2 = wr ? 3'b100 : 3'b101;
    bad_en = 0; bad_wd = 0; bad_rv = 0;
    for (int t = acc + 1; t <= acc + l; t++) begin
      m = t % N;
      if (tr_en[m] !== ((t == acc + 1) || (t == c2))) bad_en++;
      exp_wd = (wr && t >= c2 && t < c2 + 8) ? wd[32*(t - c2) +: 32] : 32'h0;
      if (tr_wd[m] !== exp_wd) bad_wd++;
      if (tr_rv[m] !== (t == acc + l)) bad_rv++;
    end
    chk("cmd_en_pattern", bad_en, 0);
    chk("wdata_stream", bad_wd, 0);
    chk("rsp_valid_timing", bad_rv, 0);
    chk("act_cmd", tr_cmd[(acc + 1) % N], 3'b011);
    chk("act_addr", tr_addr[(acc + 1) % N], {line, 3'b000});
    chk("rw_cmd", {tr_cmd[c2 % N], tr_addr[c2 % N], tr_len[c2 % N]}, {cmd2, line, 3'b000, 8'd7});
    chk("hold_at_done", {tr_cmd[(acc + l) % N], tr_addr[(acc + l) % N], tr_len[(acc + l) % N]},
        {cmd2, line, 3'b000, 8'd7});
    chk("rsp_write", tr_rw[(acc + l) % N], wr);
    if (!wr) begin
      chk("rsp_rdata", last_rsp_rdata, sb_line(line));
      exp_hold[d] = sb_line(line);
    end
  endtask

  task automatic run_req(input int d, input logic wr, input logic [17:0] line,
                         input logic [255:0] wd, input logic drop_init);
    int acc;
    logic ok;
    cur = d;
    req_write = wr; req_line_addr = line; req_wdata = wd; req_valid[d] = 1'b1;
    if (wr) sb[line] = wd;
    wait_accept(d, acc, ok);
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_write = 1'($urandom); req_line_addr = 18'($urandom); req_wdata = rand_line();
    if (drop_init) sdrc_init_done = 1'b0;
    if (ok) begin
      wait_cycle(acc + txn_lat(d, wr) + 2);
      sdrc_init_done = 1'b1;
      check_txn(d, acc, wr, line, wd);
      if (wr) chk("rsp_rdata_hold", rsp_rdata[d], exp_hold[d]);
      $display("[TB] dut%0d %s line=%05h accept@%0d", d, wr ? "WR" : "RD", line, acc);
    end
    sdrc_init_done = 1'b1;
  endtask

  task automatic back_to_back(input int d, input logic [17:0] line);
    int acc1, acc2;
    logic ok1, ok2;
    logic [255:0] wd;
    cur = d;
    wd = rand_line();
    req_write = 1'b1; req_line_addr = line; req_wdata = wd; req_valid[d] = 1'b1;
    sb[line] = wd;
    wait_accept(d, acc1, ok1);
    @(negedge clk);
    req_write = 1'b0;
    wait_accept(d, acc2, ok2);
    @(negedge clk);
    req_valid[d] = 1'b0;
    if (ok1 && ok2) begin
      chk("b2b_second_accept", acc2, acc1 + txn_lat(d, 1'b1) + 1);
      wait_cycle(acc2 + txn_lat(d, 1'b0) + 2);
      check_txn(d, acc1, 1'b1, line, wd);
      check_txn(d, acc2, 1'b0, line, wd);
      $display("[TB] dut%0d B2B line=%05h accept@%0d,%0d", d, line, acc1, acc2);
    end
  endtask

  initial begin
    int bad, acc, r_cyc;
    logic ok;
    logic [255:0] wd;
    logic [17:0] line;
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    exp_hold[0] = '0; exp_hold[1] = '0;

    // Reset takes effect before any clock edge.
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_outputs", {sdrc_cmd_en[d], sdrc_cmd[d], sdrc_addr[d], sdrc_len[d], sdrc_wdata[d],
                            rsp_valid[d], rsp_write[d], req_ready[d]}, '0);
      chk("reset_rsp_rdata", rsp_rdata[d], '0);
      chk("tie_offs", {sdrc_pc[d], sdrc_pd[d], sdrc_sr[d], sdrc_dqm[d]}, 7'b1000000);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Init gate: valid held with the controller not ready.
    req_valid[0] = 1'b1; req_valid[1] = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk); #1;
      for (int d = 0; d < 2; d++) if (req_ready[d] || sdrc_cmd_en[d]) bad++;
    end
    chk("init_gate", bad, 0);
    $display("[TB] init gate 100 cycles observed");
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    sdrc_init_done = 1'b1;
    #1 chk("ready_after_init", {req_ready[0], req_ready[1]}, 2'b11);
    @(negedge clk);

    // Directed write of line 0.
    wd = {32'habcdef04, 32'habcdef03, 32'habcdef02, 32'habceef01,
          32'habcdfefe, 32'h56781010, 32'habcdef01, 32'h12345678};
    run_req(0, 1'b1, 18'h0, wd, 1'b0);

    // Row 1: write then read back.
    wd = rand_line();
    run_req(0, 1'b1, 18'h20, wd, 1'b0);
    run_req(0, 1'b0, 18'h20, '0, 1'b0);

    // Random mix, sometimes dropping init_done mid-burst.
    for (int n = 0; n < 14; n++) begin
      line = ($urandom_range(0, 1) != 0 ? 18'h3fff0 : 18'h00040) + 18'($urandom_range(0, 7));
      run_req(0, 1'($urandom_range(0, 1)), line, rand_line(), $urandom_range(0, 3) == 0);
    end

    back_to_back(0, 18'h00123);

    // Reset in the middle of a read burst, just before word 3 is captured.
    cur = 0;
    req_write = 1'b0; req_line_addr = 18'h20; req_valid[0] = 1'b1;
    wait_accept(0, acc, ok);
    @(negedge clk);
    req_valid[0] = 1'b0;
    r_cyc = acc + 2 + rcd_of(0) + lat_of(0) + 3;
    wait_cycle(r_cyc);
    rst = 1'b1;
    #1;
    chk("midread_reset_outputs", {sdrc_cmd_en[0], sdrc_cmd[0], sdrc_addr[0], sdrc_len[0],
                                   sdrc_wdata[0], rsp_valid[0], rsp_write[0]}, '0);
    chk("midread_reset_rdata", rsp_rdata[0], '0);
    exp_hold[0] = '0; exp_hold[1] = '0;
    sdrc_init_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (req_ready[0]) bad++;
    end
    chk("ready_blocked_until_init", bad, 0);
    wait_cycle(r_cyc + 30);
    bad = 0;
    for (int t = r_cyc; t < r_cyc + 28; t++) if (tr_rv[t % N]) bad++;
    chk("no_rsp_after_reset", bad, 0);
    $display("[TB] dut0 reset mid-read at cycle %0d", r_cyc);
    sdrc_init_done = 1'b1;
    #1 chk("ready_after_reinit", req_ready[0], 1'b1);
    @(negedge clk);
    run_req(0, 1'b0, 18'h20, '0, 1'b0);

    // Swept-parameter instance.
    for (int n = 0; n < 6; n++) begin
      line = 18'h01000 + 18'($urandom_range(0, 3));
      run_req(1, (n % 2) == 0, line, rand_line(), n == 3);
    end
    back_to_back(1, 18'h2a000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
